// File: rtl/bus_cycle_sched_pkg.sv
// Shared types and defaults for the bus cycle scheduler.
package clk_sched_pkg;

  // CPU bus ownership states: running, RDY pulled low but not yet honoured, halted.
  typedef enum logic [1:0] {
    StRun,
    StStopping,
    StHalted
  } schedState_e;

  localparam int unsigned defaultLineCycles = 114;

endpackage

// File: rtl/bus_cycle_sched_if.sv
// Request/strobe bundle between the scheduler and its surroundings.
interface bus_cycle_sched_if;

  logic       dma_req;
  logic       wsync;
  logic       line_start;
  logic       cpu_rw;
  logic       phi0_en;
  logic       latch_en;
  logic       cpu_rdy;
  logic       dma_grant;
  logic [7:0] cycle_cnt;

  modport master (
    output dma_req, wsync, line_start, cpu_rw,
    input  phi0_en, latch_en, cpu_rdy, dma_grant, cycle_cnt
  );

  modport slave (
    input  dma_req, wsync, line_start, cpu_rw,
    output phi0_en, latch_en, cpu_rdy, dma_grant, cycle_cnt
  );

endinterface

// File: rtl/bus_cycle_sched_phase_gen.sv
// Machine-cycle phase counter; produces the cycle-start, latch and boundary strobes.
module phase_gen #(
  parameter int unsigned DIV       = 32,
  parameter int unsigned LATCH_POS = 12
) (
  input  logic clkin,
  input  logic RST,
  output logic phi0En,
  output logic latchEn,
  output logic boundary
);

  localparam int unsigned    PhW        = $clog2(DIV);
  localparam logic [PhW-1:0] LastPhase  = PhW'(DIV - 1);
  localparam logic [PhW-1:0] LatchPhase = PhW'(LATCH_POS);

  logic [PhW-1:0] phaseQ;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clkin) begin
    if (RST) begin
      phaseQ <= '0;
    end else if (phaseQ == LastPhase) begin
      phaseQ <= '0;
    end else begin
      phaseQ <= phaseQ + PhW'(1);
    end
  end

  // Strobes are masked while in reset so nothing fires before the first real cycle.
  assign phi0En   = !RST && (phaseQ == '0);
  assign latchEn  = !RST && (phaseQ == LatchPhase);
  assign boundary = (phaseQ == LastPhase);

endmodule

// File: rtl/bus_cycle_sched.sv
// CPU/DMA bus cycle scheduler: halts the CPU through RDY for DMA or WSYNC and
// grants the bus to DMA only once the CPU is known to be stopped on a read.
module bus_cycle_sched
  import clk_sched_pkg::*;
#(
  parameter int unsigned DIV         = 32,
  parameter int unsigned LATCH_POS   = 12,
  parameter int unsigned LINE_CYCLES = defaultLineCycles
) (
  input logic         clkin,
  input logic         RST,
  bus_cycle_sched_if.slave bus
);

  logic        phi0En;
  logic        latchEn;
  logic        boundary;

  schedState_e stateQ, stateD;
  logic        cpuRdyQ, cpuRdyD;
  logic        dmaGrantQ, dmaGrantD;
  logic [7:0]  cycleCntQ, cycleCntD;
  logic        wsyncPendQ;
  logic        lineSeenQ;
  logic        haltPend;

  phase_gen #(
    .DIV       (DIV),
    .LATCH_POS (LATCH_POS)
  ) uPhase (
    .clkin    (clkin),
    .RST      (RST),
    .phi0En   (phi0En),
    .latchEn  (latchEn),
    .boundary (boundary)
  );

  assign haltPend = bus.dma_req | wsyncPendQ;

  // WSYNC pending flag (set beats clear) and line_start memory until the next boundary.
  always_ff @(posedge clkin) begin
    if (RST) begin
      wsyncPendQ <= 1'b0;
      lineSeenQ  <= 1'b0;
    end else begin
      if (bus.wsync) begin
        wsyncPendQ <= 1'b1;
      end else if (bus.line_start) begin
        wsyncPendQ <= 1'b0;
      end
      if (boundary) begin
        lineSeenQ <= 1'b0;
      end else if (bus.line_start) begin
        lineSeenQ <= 1'b1;
      end
    end
  end

  // Next state and registered outputs, all updated only at a machine-cycle boundary.
  always_comb begin
    stateD    = stateQ;
    cpuRdyD   = cpuRdyQ;
    dmaGrantD = dmaGrantQ;
    cycleCntD = cycleCntQ;
    if (boundary) begin
      unique case (stateQ)
        StRun:      stateD = haltPend ? StStopping : StRun;
        // A write cycle ignores RDY, so only a read proves the CPU has stopped.
        StStopping: begin
          if (bus.cpu_rw) begin
            stateD = StHalted;
          end else if (!haltPend) begin
            stateD = StRun;
          end
        end
        StHalted:   stateD = haltPend ? StHalted : StRun;
        default:    stateD = StRun;
      endcase
      cpuRdyD   = (stateD == StRun);
      dmaGrantD = (stateD == StHalted) && bus.dma_req;
      if (lineSeenQ || bus.line_start || cycleCntQ == 8'(LINE_CYCLES - 1)) begin
        cycleCntD = '0;
      end else begin
        cycleCntD = cycleCntQ + 8'd1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clkin) begin
    if (RST) begin
      stateQ    <= StRun;
      cpuRdyQ   <= 1'b1;
      dmaGrantQ <= 1'b0;
      cycleCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      cpuRdyQ   <= cpuRdyD;
      dmaGrantQ <= dmaGrantD;
      cycleCntQ <= cycleCntD;
    end
  end

  assign bus.phi0_en   = phi0En;
  assign bus.latch_en  = latchEn;
  assign bus.cpu_rdy   = cpuRdyQ;
  assign bus.dma_grant = dmaGrantQ;
  assign bus.cycle_cnt = cycleCntQ;

endmodule

// File: tb/tb_bus_cycle_sched.sv
// Scoreboard bench for bus_cycle_sched: the driver predicts each machine cycle's
// outputs from a behavioural model; a negedge monitor checks them at phi0_en.
module tb_bus_cycle_sched;

  localparam int DIV         = 32;
  localparam int LATCH_POS   = 12;
  localparam int LINE_CYCLES = 114;

  typedef struct packed {
    logic       rdy;
    logic       grant;
    logic [7:0] cnt;
  } expT;

  logic clkin = 1'b0;
  logic RST;

  bus_cycle_sched_if bus ();

  bus_cycle_sched #(
    .DIV         (DIV),
    .LATCH_POS   (LATCH_POS),
    .LINE_CYCLES (LINE_CYCLES)
  ) dut (
    .clkin (clkin),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  int  vectors     = 0;
  int  miscompares = 0;
  expT expQ[$];

  // Behavioural model: is RDY held low, has the CPU actually stopped, WSYNC wait, line position.
  bit  mRdyLow, mStopped, mPend;
  int  mCnt;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic expT mkExp(input bit rdy, input bit grant, input int cnt);
    expT e;
    e.rdy   = rdy;
    e.grant = grant;
    e.cnt   = 8'(cnt);
    return e;
  endfunction

  // Apply one machine-cycle boundary to the model and queue the next cycle's outputs.
  task automatic modelBoundary(input bit req, input bit rw, input int ws, input int ls);
    bit halt;
    if (ws >= 0 && ls >= 0) mPend = (ws >= ls);
    else if (ws >= 0)       mPend = 1'b1;
    else if (ls >= 0)       mPend = 1'b0;
    halt = req || mPend;
    if (!mRdyLow) begin
      mRdyLow = halt;
    end else if (!mStopped) begin
      if (rw) mStopped = 1'b1;
      else if (!halt) mRdyLow = 1'b0;
    end else if (!halt) begin
      mRdyLow  = 1'b0;
      mStopped = 1'b0;
    end
    mCnt = (ls >= 0) ? 0 : (mCnt + 1) % LINE_CYCLES;
    expQ.push_back(mkExp(!mRdyLow, mStopped && req, mCnt));
  endtask

  // Drive one machine cycle; entered and left 1 time unit after a phase-0 edge.
  task automatic runCycle(input bit req, input bit rw, input int ws, input int ls);
    bus.dma_req = req;
    bus.cpu_rw  = rw;
    for (int ph = 0; ph < DIV; ph++) begin
      bus.wsync      = (ph == ws);
      bus.line_start = (ph == ls);
      if (ph == DIV - 1) modelBoundary(req, rw, ws, ls);
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic runPartial(input int n);
    bus.wsync      = 1'b0;
    bus.line_start = 1'b0;
    for (int ph = 0; ph < n; ph++) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic doReset();
    RST            = 1'b1;
    bus.dma_req    = 1'b0;
    bus.wsync      = 1'b0;
    bus.line_start = 1'b0;
    @(posedge clkin);
    #1;
    check("rst_phi0_en", bus.phi0_en, 0);
    check("rst_latch_en", bus.latch_en, 0);
    check("rst_cpu_rdy", bus.cpu_rdy, 1);
    check("rst_dma_grant", bus.dma_grant, 0);
    check("rst_cycle_cnt", bus.cycle_cnt, 0);
    mRdyLow  = 1'b0;
    mStopped = 1'b0;
    mPend    = 1'b0;
    mCnt     = 0;
    expQ.delete();
    expQ.push_back(mkExp(1'b1, 1'b0, 0));
    RST = 1'b0;
  endtask

  // Monitor: strobe spacing every clkin, scoreboard compare on each phi0_en.
  int  sincePhi = 0;
  bit  havePhi  = 1'b0;
  expT got;
  always @(negedge clkin) begin
    if (RST) begin
      havePhi  = 1'b0;
      sincePhi = 0;
    end else begin
      sincePhi++;
      if (havePhi) check("phi0_period", bus.phi0_en, int'(sincePhi == DIV));
      if (bus.phi0_en) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_phi0: phi0_en seen with no predicted cycle (t=%0t)", $time);
        end else begin
          got = expQ.pop_front();
          check("cpu_rdy", bus.cpu_rdy, got.rdy);
          check("dma_grant", bus.dma_grant, got.grant);
          check("cycle_cnt", bus.cycle_cnt, got.cnt);
        end
        havePhi  = 1'b1;
        sincePhi = 0;
      end else if (sincePhi >= DIV) begin
        if (!havePhi) begin
          vectors++;
          miscompares++;
          $display("FAIL phi0_missing: no phi0_en within %0d clkin of reset release", DIV);
        end
        sincePhi = 0;
      end
      if (havePhi) check("latch_pos", bus.latch_en, int'(sincePhi == LATCH_POS));
      check("grant_while_rdy", int'(bus.dma_grant && bus.cpu_rdy), 0);
    end
  end

  initial begin
    RST            = 1'b1;
    bus.dma_req    = 1'b0;
    bus.cpu_rw     = 1'b1;
    bus.wsync      = 1'b0;
    bus.line_start = 1'b0;
    repeat (2) @(posedge clkin);
    doReset();

    // DMA burst of three boundaries on read cycles.
    repeat (3) runCycle(1'b1, 1'b1, -1, -1);
    repeat (2) runCycle(1'b0, 1'b1, -1, -1);

    // DMA request while the CPU keeps writing: grant must wait for a read.
    repeat (3) runCycle(1'b1, 1'b0, -1, -1);
    runCycle(1'b1, 1'b1, -1, -1);
    repeat (2) runCycle(1'b0, 1'b1, -1, -1);

    // WSYNC and line_start on the same clkin, then a later line_start releases it.
    runCycle(1'b0, 1'b1, 5, 5);
    runCycle(1'b0, 1'b1, -1, -1);
    runCycle(1'b0, 1'b1, -1, 7);
    repeat (2) runCycle(1'b0, 1'b1, -1, -1);

    // WSYNC at cycle 40, line_start at cycle 113, plus a full line wrap on the way.
    while (mCnt != 40) runCycle(1'b0, 1'b0, -1, -1);
    runCycle(1'b0, 1'b1, 10, -1);
    while (mCnt != 113) runCycle(1'b0, 1'b1, -1, -1);
    runCycle(1'b0, 1'b1, -1, 20);
    runCycle(1'b0, 1'b1, -1, -1);

    // Reset in the middle of a granted DMA cycle.
    repeat (2) runCycle(1'b1, 1'b1, -1, -1);
    runPartial(10);
    doReset();
    runCycle(1'b0, 1'b1, -1, -1);

    // Randomised traffic with one more mid-cycle reset.
    for (int i = 0; i < 300; i++) begin
      int ws, ls;
      ws = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DIV - 2)) : -1;
      ls = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, DIV - 2)) : -1;
      runCycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, ws, ls);
      if (i == 150) begin
        runPartial(int'($urandom_range(1, DIV - 2)));
        doReset();
      end
    end

    repeat (3) @(posedge clkin);
    check("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_cycle_sched.md
BUS_CYCLE_SCHED -- requirements
Module: bus_cycle_sched

Interface
REQ-001 Parameter DIV, default 32: clkin cycles per machine cycle, legal range 8..256.
REQ-002 Parameter LATCH_POS, default 12: phase at which latch_en pulses, legal range 1..DIV-2.
REQ-003 Parameter LINE_CYCLES, default 114: machine cycles per scanline.
REQ-004 clkin  in  1  fast source clock; sole clock; all logic on posedge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 dma_req  in  1  ANTIC requests the next machine cycle.
REQ-007 wsync  in  1  one-clkin pulse on a CPU write to WSYNC.
REQ-008 line_start  in  1  one-clkin pulse at scanline start.
REQ-009 cpu_rw  in  1  CPU current-cycle direction, 1 = read.
REQ-010 phi0_en  out  1  one-clkin strobe at machine-cycle start.
REQ-011 latch_en  out  1  one-clkin strobe at phase LATCH_POS.
REQ-012 cpu_rdy  out  1  CPU RDY line, 0 = halt requested.
REQ-013 dma_grant  out  1  bus owned by DMA for the whole current machine cycle.
REQ-014 cycle_cnt  out  8  machine-cycle index within the scanline.

Function
REQ-015 phase SHALL count 0..DIV-1 and wrap to 0; phi0_en = (phase==0), latch_en = (phase==LATCH_POS).
REQ-016 Boundary = clkin cycle with phase==DIV-1; dma_req, cpu_rw and halt_pend SHALL be sampled only at a boundary, and new state/outputs SHALL take effect together with the next phi0_en.
REQ-017 halt_pend = dma_req OR wsync_pend.
REQ-018 wsync_pend SHALL set on wsync and clear on line_start; on simultaneous wsync and line_start, set wins.
REQ-019 States: RUN, STOPPING, HALTED.
REQ-020 RUN: boundary with halt_pend -> STOPPING, cpu_rdy=0; otherwise stay, cpu_rdy=1.
REQ-021 STOPPING: boundary with cpu_rw=1 -> HALTED; cpu_rw=0 (6502 ignores RDY on writes) -> stay; halt_pend=0 -> RUN, cpu_rdy=1 (cpu_rw check takes priority over halt_pend drop).
REQ-022 HALTED: boundary with halt_pend -> stay, cpu_rdy=0; otherwise -> RUN, cpu_rdy=1.
REQ-023 dma_grant SHALL be 1 for a machine cycle iff state is HALTED at that cycle's start and dma_req was 1 at the preceding boundary; otherwise 0.
REQ-024 dma_grant and a STOPPING state SHALL never coexist (DMA never granted while CPU may drive a write).
REQ-025 cycle_cnt SHALL increment at each boundary and wrap from LINE_CYCLES-1 to 0; a line_start seen since the previous boundary SHALL force 0 at the next boundary, overriding increment.
REQ-026 cpu_rdy, dma_grant and cycle_cnt SHALL be registered; phi0_en and latch_en SHALL decode the registered phase only.

Reset
REQ-027 While RST=1: phase=0, state=RUN, wsync_pend=0, cpu_rdy=1, dma_grant=0, cycle_cnt=0, phi0_en=0, latch_en=0.
REQ-028 First clkin after RST deasserts SHALL have phase=0 and phi0_en=1.
REQ-029 RST mid-cycle or mid-halt SHALL abort immediately; no pending DMA or WSYNC survives.

Structure
REQ-030 Package clk_sched_pkg SHALL hold the state enum and LINE_CYCLES default.
REQ-031 Sub-module phase_gen SHALL own the phase counter, phi0_en, latch_en and boundary strobe; the FSM stays in bus_cycle_sched.
REQ-032 Target size 150-300 RTL lines; no derived clocks, enables only.

Verification
REQ-033 DIV=32: after reset, phi0_en every 32 clkin, latch_en 12 clkin after each phi0_en; cycle_cnt reaches 113 then 0.
REQ-034 dma_req=1 for 3 boundaries, cpu_rw=1: cpu_rdy=0 from next cycle, HALTED one cycle later, dma_grant=1 for 2 cycles, cpu_rdy=1 after dma_req drops.
REQ-035 dma_req=1 while cpu_rw=0 for 2 boundaries then 1: STOPPING held 2 cycles, dma_grant=0 throughout, grant only after cpu_rw=1 sampled.
REQ-036 wsync at cycle_cnt=40, line_start at cycle_cnt=113: cpu_rdy=0 from cycle 41 until first cycle after line_start, cycle_cnt=0 there.
REQ-037 wsync and line_start same clkin: wsync_pend remains 1, CPU halts.
REQ-038 RST pulsed during dma_grant=1: next clkin all outputs at REQ-027 values, phi0_en=1 on first post-reset clkin.
